ika2151_regwr_sched: RTL and testbench
======================================

# ika2151_regwr_sched

Register-write scheduler between the CPU bus interface and the operator/channel register file. Accepts address and data writes from the bus, generates the BUSY status, and commits each data write into the register file at the correct time-multiplexed slot. The slot is selected by comparing against the 5-bit cycle counter driven by the timing generator. Runs on the emulator master clock; all scheduling advances on phi1 negative-edge clock enables.

## Interface

Parameters:
- `BUSY_CYCLES`, default 64: number of phi1 cycles BUSY stays high per accepted data write. Legal range is 34..127.

Ports:
- `i_EMUCLK`  in  1  emulator master clock.
- `i_RST`  in  1  synchronous reset, active-high. One clock domain only.
- `i_phi1_NCEN_n`  in  1  phi1 negative-edge clock enable, active-low. Scheduling state advances only when low.
- `i_CYCLE`  in  5  current slot counter (0..31) from the timing generator.
- `i_WR_EN`  in  1  bus write strobe, one `i_EMUCLK` wide.
- `i_A0`  in  1  0 = address write, 1 = data write.
- `i_DIN`  in  8  bus write data.
- `o_BUSY`  out  1  write-busy status.
- `o_REG_ADDR`  out  8  committed register address.
- `o_REG_DATA`  out  8  committed register data.
- `o_GLOBAL_WE`  out  1  write enable for global registers 0x00–0x1F.
- `o_SLOT_WE`  out  1  write enable for channel/operator registers 0x20–0xFF.
- `o_OVERRUN`  out  1  sticky flag: a data write was dropped.

## Operation

- **Address latch**
  - Loaded from `i_DIN` on any address write, sampled every `i_EMUCLK`.
  - Accepted even while busy.
- **Data write accept**
  - Accepted only when the FSM is IDLE and the busy counter is 0.
  - On accept: snapshot the address latch and `i_DIN` into the pending registers, load the busy counter with `BUSY_CYCLES`, go to WAIT.
  - A data write while busy is dropped; see Configuration.
- **Target slot**
  - Address < 0x20: global register, no slot.
  - 0x20–0x3F: channel register, target = {2'b00, addr[2:0]}.
  - 0x40–0xFF: operator register, target = addr[4:0].
- **FSM** (transitions only on enable cycles, where `i_phi1_NCEN_n` = 0)
  - IDLE: waits for an accepted data write.
  - WAIT → COMMIT:
    - global register: at the first enable after accept;
    - otherwise: at the first enable where `i_CYCLE` == target.
  - COMMIT: drives the selected WE high for exactly one phi1 period, with `o_REG_ADDR`/`o_REG_DATA` valid. Goes to HOLD at the next enable.
  - HOLD: waits until the busy counter reaches 0, then returns to IDLE.
- **Busy counter**
  - 7 bits, decrements on each enable while nonzero.
  - `o_BUSY` = (state ≠ IDLE) | (counter ≠ 0).
  - Because `BUSY_CYCLES` ≥ 34, the counter always outlives the worst-case slot wait of 32 cycles.
- Exactly one of `o_GLOBAL_WE` / `o_SLOT_WE` is ever high at a time.

## Timing

- **Reset**
  - On `i_RST` at any point: outputs `o_BUSY`, both WEs and `o_OVERRUN` = 0; `o_REG_ADDR` = 0x00; `o_REG_DATA` = 0x00.
  - State goes to IDLE, counter to 0, address latch to 0x00.
  - Any pending write is discarded with no WE.
- **BUSY latency:** `o_BUSY` rises on the `i_EMUCLK` edge after the accepting strobe, independent of the enable.
- **Write-enable timing**
  - WEs and data outputs are registered and change only on enable edges.
  - For a slot write, the WE rises at the enable where `i_CYCLE` == target and stays high through the following phi1 period.
  - For a global write, the WE rises at the first enable strictly after accept.
- **Strobe coincident with an enable:** the accept happens at that edge; the slot comparison starts at the next enable. A target equal to the current `i_CYCLE` therefore waits 32 cycles.
- **Deassert point:** BUSY falls at the enable where the counter goes 1 → 0, i.e. `BUSY_CYCLES` enables after accept.
- **Address and data on the same edge:** impossible, since one strobe carries one `i_A0`. An address write in the same cycle as an accept does not affect the snapshot, which uses the old latch value.

## Configuration

- Macro: `IKA2151_OVERRUN_FLAG_EN`.
- **Defined:** a data write dropped while busy sets `o_OVERRUN` on the next `i_EMUCLK`. It stays set until `i_RST`.
- **Undefined:** `o_OVERRUN` is tied to 0 and no flag register is synthesized. Dropped writes are silently ignored.

## Structure

- **Shared package `ika2151_pkg`:**
  - FSM state enum (IDLE, WAIT, COMMIT, HOLD);
  - region boundary constants 0x20 and 0x40;
  - 7-bit busy counter width.
- **Sub-module `ika2151_slot_decode`:** combinational. Maps an 8-bit address to a global flag plus the 5-bit target slot. It is reused by the register file's read-back path.

## Test plan

- Address write 0x08, data write 0x5A, with `BUSY_CYCLES` = 64 → `o_GLOBAL_WE` pulse at the next enable with addr 0x08 / data 0x5A; `o_BUSY` high for 64 enables.
- Address 0x2B, data 0xC3 → `o_SLOT_WE` rises at the enable with `i_CYCLE` = 3, addr 0x2B; no other WE.
- Address 0x5F, data 0x11, strobe coincident with an enable where `i_CYCLE` = 31 → WE at `i_CYCLE` = 31, 32 enables later.
- Second data write 10 enables after the first → dropped, only one WE, `o_OVERRUN` = 1 (macro defined) or 0 (macro undefined).
- `i_RST` asserted during WAIT → no WE ever, `o_BUSY` = 0 on the next clock, a new write is accepted immediately after release.
- Address write 0x30 during HOLD, then data write 0x77 after BUSY falls → commit at `i_CYCLE` = 0 with addr 0x30 / data 0x77.

Source files
------------

// File: rtl/ika2151_pkg.sv
// ika2151_pkg: shared FSM state, register-region boundaries and busy-counter width
package ika2151_pkg;
    typedef enum logic [1:0] {ST_IDLE, ST_WAIT, ST_COMMIT, ST_HOLD} wr_state_e;
    localparam logic [7:0] CH_BASE = 8'h20;
    localparam logic [7:0] OP_BASE = 8'h40;
    localparam int BUSY_W = 7;
endpackage

// File: rtl/ika2151_slot_decode.sv
// ika2151_slot_decode: maps a register address to a global flag and its 5-bit time slot
module ika2151_slot_decode
    import ika2151_pkg::*;
(
    input  logic [7:0] i_addr,
    output logic       o_global,
    output logic [4:0] o_slot
);
    assign o_global = i_addr < CH_BASE;
    assign o_slot   = i_addr < OP_BASE ? {2'b00, i_addr[2:0]} : i_addr[4:0];
endmodule

// File: rtl/ika2151_regwr_sched.sv
// ika2151_regwr_sched: schedules CPU register writes into time-multiplexed register-file slots
// Optional sticky overrun flag: define IKA2151_OVERRUN_FLAG_EN
module ika2151_regwr_sched
    import ika2151_pkg::*;
#(
    parameter int BUSY_CYCLES = 64
) (
    input  logic       i_EMUCLK,
    input  logic       i_RST,
    input  logic       i_phi1_NCEN_n,
    input  logic [4:0] i_CYCLE,
    input  logic       i_WR_EN,
    input  logic       i_A0,
    input  logic [7:0] i_DIN,
    output logic       o_BUSY,
    output logic [7:0] o_REG_ADDR,
    output logic [7:0] o_REG_DATA,
    output logic       o_GLOBAL_WE,
    output logic       o_SLOT_WE,
    output logic       o_OVERRUN
);
    localparam logic [BUSY_W-1:0] BUSY_LOAD = BUSY_W'(BUSY_CYCLES);

    wr_state_e         state_q, state_d;
    logic [BUSY_W-1:0] cnt_q, cnt_d;
    logic [7:0]        addr_lat_q, addr_lat_d;
    logic [7:0]        pend_addr_q, pend_addr_d;
    logic [7:0]        pend_data_q, pend_data_d;
    logic [7:0]        reg_addr_q, reg_addr_d;
    logic [7:0]        reg_data_q, reg_data_d;
    logic              gwe_q, gwe_d;
    logic              swe_q, swe_d;
    logic              pend_global;
    logic [4:0]        pend_slot;
    logic              en, accept;

    ika2151_slot_decode u_decode (
        .i_addr   (pend_addr_q),
        .o_global (pend_global),
        .o_slot   (pend_slot)
    );

    assign en     = ~i_phi1_NCEN_n;
    assign accept = i_WR_EN & i_A0 & (state_q == ST_IDLE) & (cnt_q == '0);

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        addr_lat_d  = (i_WR_EN && !i_A0) ? i_DIN : addr_lat_q;
        pend_addr_d = pend_addr_q;
        pend_data_d = pend_data_q;
        reg_addr_d  = reg_addr_q;
        reg_data_d  = reg_data_q;
        gwe_d       = gwe_q;
        swe_d       = swe_q;
        if (en && cnt_q != '0) cnt_d = cnt_q - 1'b1;
        case (state_q)
            ST_IDLE: if (accept) begin
                state_d     = ST_WAIT;
                cnt_d       = BUSY_LOAD;
                pend_addr_d = addr_lat_q;
                pend_data_d = i_DIN;
            end
            ST_WAIT:   if (en && (pend_global || i_CYCLE == pend_slot)) state_d = ST_COMMIT;
            ST_COMMIT: if (en) state_d = ST_HOLD;
            ST_HOLD:   if (en && cnt_q < 7'd2) state_d = ST_IDLE;
            default:   state_d = ST_IDLE;
        endcase
        // WEs and commit data are registered on enable edges only, spanning one phi1 period
        if (en) begin
            gwe_d = (state_d == ST_COMMIT) && pend_global;
            swe_d = (state_d == ST_COMMIT) && !pend_global;
            if (state_q == ST_WAIT && state_d == ST_COMMIT) begin
                reg_addr_d = pend_addr_q;
                reg_data_d = pend_data_q;
            end
        end
    end

    always_ff @(posedge i_EMUCLK) begin
        if (i_RST) begin
            state_q     <= ST_IDLE;
            cnt_q       <= '0;
            addr_lat_q  <= '0;
            pend_addr_q <= '0;
            pend_data_q <= '0;
            reg_addr_q  <= '0;
            reg_data_q  <= '0;
            gwe_q       <= 1'b0;
            swe_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            addr_lat_q  <= addr_lat_d;
            pend_addr_q <= pend_addr_d;
            pend_data_q <= pend_data_d;
            reg_addr_q  <= reg_addr_d;
            reg_data_q  <= reg_data_d;
            gwe_q       <= gwe_d;
            swe_q       <= swe_d;
        end
    end

`ifdef IKA2151_OVERRUN_FLAG_EN
    logic overrun_q, overrun_d;
    assign overrun_d = overrun_q | (i_WR_EN & i_A0 & ~accept);
    always_ff @(posedge i_EMUCLK) begin
        if (i_RST) overrun_q <= 1'b0;
        else overrun_q <= overrun_d;
    end
    assign o_OVERRUN = overrun_q;
`else
    assign o_OVERRUN = 1'b0;
`endif

    assign o_BUSY      = (state_q != ST_IDLE) | (cnt_q != '0);
    assign o_REG_ADDR  = reg_addr_q;
    assign o_REG_DATA  = reg_data_q;
    assign o_GLOBAL_WE = gwe_q;
    assign o_SLOT_WE   = swe_q;
endmodule

// File: tb/tb_ika2151_regwr_sched.sv
// tb_ika2151_regwr_sched: directed vectors for the register-write scheduler (BUSY_CYCLES = 64)
module tb_ika2151_regwr_sched;
    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       ncen = 1'b1;
    logic [4:0] cycle = '0;
    logic       wr_en = 1'b0;
    logic       a0 = 1'b0;
    logic [7:0] din = '0;
    logic       o_BUSY, o_GLOBAL_WE, o_SLOT_WE, o_OVERRUN;
    logic [7:0] o_REG_ADDR, o_REG_DATA;

    int n_vec = 0, n_err = 0;
    int div = 0, n_en = 0, n_gwe = 0, n_swe = 0, rise_en = 0;
    logic [4:0] rise_cyc = '0;
    logic [7:0] rise_addr = '0, rise_data = '0;
    logic gwe_prev = 1'b0, swe_prev = 1'b0, both_hi = 1'b0;
    logic exp_ovr;

    ika2151_regwr_sched #(.BUSY_CYCLES(64)) dut (
        .i_EMUCLK      (clk),
        .i_RST         (rst),
        .i_phi1_NCEN_n (ncen),
        .i_CYCLE       (cycle),
        .i_WR_EN       (wr_en),
        .i_A0          (a0),
        .i_DIN         (din),
        .o_BUSY        (o_BUSY),
        .o_REG_ADDR    (o_REG_ADDR),
        .o_REG_DATA    (o_REG_DATA),
        .o_GLOBAL_WE   (o_GLOBAL_WE),
        .o_SLOT_WE     (o_SLOT_WE),
        .o_OVERRUN     (o_OVERRUN)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // one clock; enable is low one clock in four and the slot counter advances after each enable edge
    task automatic tick();
        logic e;
        logic [4:0] c;
        e = !ncen;
        c = cycle;
        @(posedge clk);
        #1;
        if (e) begin
            n_en++;
            cycle = cycle + 5'd1;
        end
        div = (div + 1) % 4;
        ncen = (div != 3);
        if (o_GLOBAL_WE && !gwe_prev) begin
            n_gwe++; rise_cyc = c; rise_en = n_en; rise_addr = o_REG_ADDR; rise_data = o_REG_DATA;
        end
        if (o_SLOT_WE && !swe_prev) begin
            n_swe++; rise_cyc = c; rise_en = n_en; rise_addr = o_REG_ADDR; rise_data = o_REG_DATA;
        end
        if (o_GLOBAL_WE && o_SLOT_WE) both_hi = 1'b1;
        gwe_prev = o_GLOBAL_WE;
        swe_prev = o_SLOT_WE;
    endtask

    task automatic wr(input logic a, input logic [7:0] d);
        wr_en = 1'b1; a0 = a; din = d;
        tick();
        wr_en = 1'b0;
    endtask

    task automatic clr();
        n_gwe = 0; n_swe = 0; n_en = 0; rise_en = 0;
    endtask

    task automatic wait_idle(input string tag);
        for (int i = 0; i < 600 && o_BUSY; i++) tick();
        chk({tag, "_timeout"}, o_BUSY, 0);
    endtask

    initial begin
`ifdef IKA2151_OVERRUN_FLAG_EN
        exp_ovr = 1'b1;
`else
        exp_ovr = 1'b0;
`endif
        repeat (3) tick();
        chk("rst_busy", o_BUSY, 0);
        chk("rst_gwe", o_GLOBAL_WE, 0);
        chk("rst_swe", o_SLOT_WE, 0);
        chk("rst_ovr", o_OVERRUN, 0);
        chk("rst_addr", o_REG_ADDR, 8'h00);
        chk("rst_data", o_REG_DATA, 8'h00);
        rst = 1'b0;
        tick();

        // global write
        clr();
        wr(1'b0, 8'h08);
        wr(1'b1, 8'h5A);
        chk("g_busy_rise", o_BUSY, 1);
        n_en = 0;
        wait_idle("g");
        chk("g_busy_len", n_en, 64);
        chk("g_n_gwe", n_gwe, 1);
        chk("g_n_swe", n_swe, 0);
        chk("g_rise_en", rise_en, 1);
        chk("g_addr", rise_addr, 8'h08);
        chk("g_data", rise_data, 8'h5A);

        // channel register, target slot 3
        clr();
        wr(1'b0, 8'h2B);
        wr(1'b1, 8'hC3);
        n_en = 0;
        wait_idle("ch");
        chk("ch_busy_len", n_en, 64);
        chk("ch_n_swe", n_swe, 1);
        chk("ch_n_gwe", n_gwe, 0);
        chk("ch_cyc", rise_cyc, 3);
        chk("ch_addr", rise_addr, 8'h2B);
        chk("ch_data", rise_data, 8'hC3);

        // operator slot 31, strobe on the enable edge where cycle is 31
        clr();
        wr(1'b0, 8'h5F);
        for (int i = 0; i < 300 && !(ncen == 1'b0 && cycle == 5'd31); i++) tick();
        chk("op_align", {ncen, cycle}, {1'b0, 5'd31});
        wr(1'b1, 8'h11);
        n_en = 0;
        wait_idle("op");
        chk("op_n_swe", n_swe, 1);
        chk("op_cyc", rise_cyc, 31);
        chk("op_rise_en", rise_en, 32);
        chk("op_data", rise_data, 8'h11);

        // second data write while busy is dropped
        clr();
        wr(1'b0, 8'h10);
        wr(1'b1, 8'hAA);
        n_en = 0;
        for (int i = 0; i < 100 && n_en < 10; i++) tick();
        wr(1'b1, 8'hBB);
        tick();
        chk("ovr_flag", o_OVERRUN, exp_ovr);
        wait_idle("ovr");
        chk("ovr_n_gwe", n_gwe, 1);
        chk("ovr_data", rise_data, 8'hAA);
        chk("ovr_sticky", o_OVERRUN, exp_ovr);

        // reset during WAIT discards the pending write
        clr();
        wr(1'b0, 8'h25);
        wr(1'b1, 8'h66);
        rst = 1'b1;
        tick();
        chk("rw_busy", o_BUSY, 0);
        chk("rw_ovr", o_OVERRUN, 0);
        rst = 1'b0;
        wr(1'b1, 8'h44);
        chk("rw_accept", o_BUSY, 1);
        wait_idle("rw");
        chk("rw_n_swe", n_swe, 0);
        chk("rw_n_gwe", n_gwe, 1);
        chk("rw_addr", rise_addr, 8'h00);
        chk("rw_data", rise_data, 8'h44);

        // address write during HOLD is used by the next data write
        clr();
        wr(1'b0, 8'h12);
        wr(1'b1, 8'h99);
        n_en = 0;
        for (int i = 0; i < 100 && n_en < 5; i++) tick();
        wr(1'b0, 8'h30);
        wait_idle("hold");
        clr();
        wr(1'b1, 8'h77);
        wait_idle("hold2");
        chk("hold_n_swe", n_swe, 1);
        chk("hold_cyc", rise_cyc, 0);
        chk("hold_addr", rise_addr, 8'h30);
        chk("hold_data", rise_data, 8'h77);
        chk("we_exclusive", both_hi, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
